line_fill_ctrl: RTL and testbench
=================================

// Module: line_fill_ctrl
// PURPOSE
//  Cache line-fill sequencer. On a miss it requests the line from memory,
//  accepts 32 word beats and steps a 5-bit word offset through a one-hot
//  5-to-32 decode, so each beat writes exactly one word slot of the line.
//  Sits between the cache miss logic and the memory bus.
// PARAMETERS
//  ADDR_W       32   byte-address width
//  WORD_W       32   word width (power of 2, >=8); BYTE_W = $clog2(WORD_W/8)
//  TIMEOUT_CYC  255  idle cycles tolerated in REQ/FILL before abort; 0 = no timeout
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst_n        in   1       synchronous reset, active low
//  miss_req     in   1       fill request; sampled only in IDLE
//  miss_addr    in   ADDR_W  missing byte address; offset = miss_addr[BYTE_W+4:BYTE_W]
//  mem_req      out  1       memory read request, held until mem_ack
//  mem_addr     out  ADDR_W  memory start address
//  mem_ack      in   1       memory accepted request
//  mem_valid    in   1       data beat valid
//  mem_data     in   WORD_W  data beat
//  line_we      out  32      one-hot word write enable into line storage
//  line_wdata   out  WORD_W  write data (= mem_data)
//  fill_busy    out  1       high in REQ, FILL, DONE
//  fill_done    out  1       one-cycle pulse ending a fill
//  fill_err     out  1       valid with fill_done; 1 = timeout abort
//  crit_valid   out  1       pulse: beat for the missed word is being written
// BEHAVIOUR
//  - Reset (rst_n=0 at a posedge): state IDLE, offset/beat/timeout counters 0,
//    every output 0. Reset mid-fill abandons the fill silently: no fill_done.
//  - States IDLE -> REQ -> FILL -> DONE -> IDLE.
//  - IDLE: miss_req=1 latches miss_addr, next state REQ. mem_valid ignored.
//  - REQ: mem_req=1, mem_addr driven from latched address. mem_ack=1 -> FILL
//    next cycle, mem_req low from that cycle. Beats in REQ are ignored.
//  - FILL: cycle with mem_valid=1 -> same cycle line_we = 1<<offset,
//    line_wdata = mem_data; offset increments mod 32 (31 wraps to 0); beat
//    count +1. After 32nd beat -> DONE. mem_valid=0 cycles: line_we=0, no advance.
//  - line_we is combinational from state, offset and mem_valid; never more
//    than one bit set; zero outside FILL.
//  - crit_valid=1 in the FILL cycle writing offset == latched miss offset.
//  - Timeout: counter cleared on entry to REQ, on mem_ack and on each beat;
//    reaching TIMEOUT_CYC in REQ or FILL -> DONE with fill_err=1 and mem_req
//    dropped. Beat and timeout in same cycle: beat wins.
//  - DONE: fill_done=1 one cycle, fill_err valid; next IDLE. miss_req in
//    REQ/FILL/DONE ignored; requester re-asserts after fill_done.
//  - Latency: mem_ack to first possible write 1 cycle; last beat to fill_done 1 cycle.
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN defined: mem_addr = latched address with low BYTE_W
//    bits zeroed; offset starts at miss offset and wraps, so crit_valid
//    fires on the first beat.
//  Not defined: mem_addr line-aligned (low BYTE_W+5 bits zeroed); offset
//    starts at 0; crit_valid fires on beat number = miss offset.
// TESTING
//  1 Reset mid-fill after 10 beats, rst_n=0 2 cycles -> all outputs 0, no
//    fill_done; next miss_req accepted normally.
//  2 Macro off, miss_addr=0x0000_1234, mem_ack 2 cycles late, 32 back-to-back
//    beats data=i -> mem_addr=0x0000_1200, line_we=1<<i with data i,
//    crit_valid on beat 13, fill_done=1 fill_err=0 next cycle after beat 31.
//  3 mem_valid every other cycle -> exactly 32 writes, offsets 0..31 in
//    order, none skipped or repeated, line_we=0 on gap cycles.
//  4 TIMEOUT_CYC=16, mem_ack never asserted -> fill_done=1, fill_err=1
//    16 cycles after entering REQ; mem_req low in DONE; no line_we.
//  5 Macro on, miss_addr=0x0000_1278 -> mem_addr=0x0000_1278, write order
//    30,31,0..29; crit_valid on first beat; fill_done after 32 beats.
//  6 miss_req pulsed during FILL and mem_valid pulsed in IDLE -> both
//    ignored: no state change, line_we stays 0.

Source files
------------

// File: rtl/line_fill_if.sv
// Cache-miss / memory-bus bundle for the line-fill sequencer.
// Latency: n/a (wires only).
// Backpressure: n/a; the master asserts mem_req until mem_ack, and beats are only qualified by mem_valid.
interface line_fill_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_valid;
  logic [WORD_W-1:0] mem_data;
  logic [31:0]       line_we;
  logic [WORD_W-1:0] line_wdata;
  logic              fill_busy;
  logic              fill_done;
  logic              fill_err;
  logic              crit_valid;

  // Sequencer side: takes the miss and the memory beats, drives requests and line writes.
  modport master (
    input  miss_req, miss_addr, mem_ack, mem_valid, mem_data,
    output mem_req, mem_addr, line_we, line_wdata,
    output fill_busy, fill_done, fill_err, crit_valid
  );

  // Environment side: cache miss logic, memory bus and line storage.
  modport slave (
    output miss_req, miss_addr, mem_ack, mem_valid, mem_data,
    input  mem_req, mem_addr, line_we, line_wdata,
    input  fill_busy, fill_done, fill_err, crit_valid
  );
endinterface

// File: rtl/line_fill_ctrl.sv
// Cache line-fill sequencer: requests a line, writes 32 beats one-hot into line storage.
// Latency: mem_ack -> first write 1 cycle; last beat -> fill_done 1 cycle; beat writes are combinational.
// Backpressure: none taken; beats are absorbed whenever mem_valid is high, stalls abort after TIMEOUT_CYC.
// Build option: define CRITICAL_WORD_FIRST_EN to request the missed word first and wrap.
module line_fill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  line_fill_if.master bus
);

  localparam int BYTE_W   = $clog2(WORD_W / 8);
  localparam int TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  // Word-aligned and line-aligned address masks.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((64'd1 << BYTE_W) - 64'd1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << (BYTE_W + 5)) - 64'd1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        offset;
  logic [4:0]        miss_off;
  logic [4:0]        beat_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              err_q, err_nx;
  logic              beat;
  logic              tmo_hit;
  logic [4:0]        req_off;

  assign beat    = (state == FILL) && bus.mem_valid;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TW'(TMO_LAST));
  assign req_off = bus.miss_addr[BYTE_W+4:BYTE_W];

  // State and error-flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  // Latch the miss and walk the word offset one step per accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      miss_off <= '0;
      offset   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE && bus.miss_req) begin
      addr_q   <= bus.miss_addr;
      miss_off <= req_off;
`ifdef CRITICAL_WORD_FIRST_EN
      offset   <= req_off;
`else
      offset   <= 5'd0;
`endif
      beat_cnt <= '0;
    end else if (beat) begin
      offset   <= offset + 5'd1;
      beat_cnt <= beat_cnt + 5'd1;
    end
  end

  // Stall counter: restarts on entry to REQ, on the ack and on every beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || state == DONE) begin
      tmo_cnt <= '0;
    end else if ((state == REQ && bus.mem_ack) || beat) begin
      tmo_cnt <= '0;
    end else if (TIMEOUT_CYC != 0) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Next state; a beat in the stall-limit cycle still counts and wins over the abort.
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        err_nx = 1'b0;
        if (bus.miss_req) state_nx = REQ;
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_nx = FILL;
        end else if (tmo_hit) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      FILL: begin
        if (beat) begin
          if (beat_cnt == 5'd31) state_nx = DONE;
        end else if (tmo_hit) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; line_we follows mem_valid in the same cycle.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.line_we    = '0;
    bus.line_wdata = '0;
    bus.crit_valid = 1'b0;
    bus.fill_busy  = (state != IDLE);
    bus.fill_done  = (state == DONE);
    bus.fill_err   = (state == DONE) && err_q;
    if (state == REQ) begin
      bus.mem_req = 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
      bus.mem_addr = addr_q & WORD_MASK;
`else
      bus.mem_addr = addr_q & LINE_MASK;
`endif
    end
    if (state == FILL) bus.line_wdata = bus.mem_data;
    if (beat) begin
      bus.line_we    = 32'd1 << offset;
      bus.crit_valid = (offset == miss_off);
    end
  end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Scoreboard bench for line_fill_ctrl: a transaction-level fill model pushes expected
// writes, completions and request addresses; a negedge monitor pops and compares them.
// Expectations follow the CRITICAL_WORD_FIRST_EN build option when it is defined.
module tb_line_fill_ctrl;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_fill_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  line_fill_ctrl #(.ADDR_W(32), .WORD_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int cyc; logic [31:0] we; logic [31:0] data; logic crit; } wr_t;
  typedef struct { int cyc; logic err; } done_t;
  typedef struct { int cyc; logic [31:0] addr; } addr_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  addr_t exp_addr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.miss_req  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = $urandom;
  endtask

  // Memory start address the requester should see for a miss.
  function automatic logic [31:0] line_addr(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return a & 32'hFFFF_FFFC;
`else
    return a & 32'hFFFF_FF80;
`endif
  endfunction

  // Word slot written by beat k of a fill for miss address a.
  function automatic int slot_of(input logic [31:0] a, input int k);
    int miss_word;
    miss_word = int'((a >> 2) & 32'h1F);
`ifdef CRITICAL_WORD_FIRST_EN
    return (miss_word + k) % 32;
`else
    return k;
`endif
  endfunction

  // Whether beat k carries the word that missed.
  function automatic logic crit_beat(input logic [31:0] a, input int k);
    int miss_word;
    miss_word = int'((a >> 2) & 32'h1F);
`ifdef CRITICAL_WORD_FIRST_EN
    return (k == 0);
`else
    return (k == miss_word);
`endif
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_req"},    32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_addr"},   bus.mem_addr, 32'd0);
    chk({tag, "_line_we"},    bus.line_we, 32'd0);
    chk({tag, "_line_wdata"}, bus.line_wdata, 32'd0);
    chk({tag, "_busy"},       32'(bus.fill_busy), 32'd0);
    chk({tag, "_done"},       32'(bus.fill_done), 32'd0);
    chk({tag, "_err"},        32'(bus.fill_err), 32'd0);
    chk({tag, "_crit"},       32'(bus.crit_valid), 32'd0);
  endtask

  // Mem valid chatter while idle must not start or disturb anything.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      bus.mem_valid = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
  endtask

  // One fill transaction. ack_dly: idle REQ cycles before mem_ack (>= TMO never acks).
  // gmode: 0 back-to-back, 1 one-cycle gaps, 2 gaps 0..3, 3 mostly short with rare stalls.
  // rst_after: assert reset after that many beats (-1 = never).
  task automatic run_fill(input logic [31:0] addr, input int ack_dly, input int gmode,
                          input bit idx_data, input bit noise, input int rst_after);
    int idle;
    int gap;
    logic [31:0] d;
    clear_inputs();
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    if (noise) bus.mem_valid = 1'($urandom_range(0, 1));
    exp_addr.push_back('{cyc + 1, line_addr(addr)});
    step();
    // Request phase: the stall limit counts from the first REQ cycle.
    idle = 0;
    for (int w = 0; ; w++) begin
      clear_inputs();
      if (noise) begin
        bus.miss_req  = 1'($urandom_range(0, 1));
        bus.miss_addr = $urandom;
        bus.mem_valid = 1'($urandom_range(0, 1));
      end
      if (w == ack_dly) begin
        bus.mem_ack = 1'b1;
        step();
        break;
      end
      idle++;
      if (idle == TMO) begin
        exp_done.push_back('{cyc + 1, 1'b1});
        step();
        clear_inputs();
        step();
        clear_inputs();
        return;
      end
      step();
    end
    // Data phase.
    idle = 0;
    for (int k = 0; k < 32; k++) begin
      case (gmode)
        0:       gap = 0;
        1:       gap = 1;
        2:       gap = $urandom_range(0, 3);
        default: gap = ($urandom_range(0, 59) == 0) ? $urandom_range(TMO - 1, TMO + 3)
                                                    : $urandom_range(0, 2);
      endcase
      for (int g = 0; g < gap; g++) begin
        clear_inputs();
        if (noise) begin
          bus.miss_req  = 1'($urandom_range(0, 1));
          bus.miss_addr = $urandom;
        end
        idle++;
        if (idle == TMO) begin
          exp_done.push_back('{cyc + 1, 1'b1});
          step();
          clear_inputs();
          step();
          clear_inputs();
          return;
        end
        step();
      end
      clear_inputs();
      if (noise) begin
        bus.miss_req  = 1'($urandom_range(0, 1));
        bus.miss_addr = $urandom;
      end
      d = idx_data ? 32'(k) : $urandom;
      bus.mem_valid = 1'b1;
      bus.mem_data  = d;
      exp_wr.push_back('{cyc, 32'd1 << slot_of(addr, k), d, crit_beat(addr, k)});
      if (k == 31) exp_done.push_back('{cyc + 1, 1'b0});
      idle = 0;
      step();
      if (k + 1 == rst_after) begin
        clear_inputs();
        rst_n = 1'b0;
        step();
        check_quiet("rst1");
        step();
        check_quiet("rst2");
        rst_n = 1'b1;
        step();
        return;
      end
    end
    // DONE cycle, then back to IDLE.
    clear_inputs();
    if (noise) bus.miss_req = 1'($urandom_range(0, 1));
    step();
    clear_inputs();
  endtask

  // Monitor: every DUT output event must match the head of its expectation queue.
  wr_t   mw;
  done_t md;
  addr_t ma;
  logic  prev_req = 1'b0;

  always @(negedge clk) begin
    if (bus.line_we !== 32'd0) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", bus.line_we, 32'd0);
      end else begin
        mw = exp_wr.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(mw.cyc));
        chk("wr_line_we", bus.line_we, mw.we);
        chk("wr_data", bus.line_wdata, mw.data);
        chk("wr_crit", 32'(bus.crit_valid), 32'(mw.crit));
      end
    end else if (bus.crit_valid) begin
      chk("crit_without_write", 32'(bus.crit_valid), 32'd0);
    end
    if (bus.fill_done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 32'(bus.fill_done), 32'd0);
      end else begin
        md = exp_done.pop_front();
        chk("done_cycle", 32'(cyc), 32'(md.cyc));
        chk("done_err", 32'(bus.fill_err), 32'(md.err));
        chk("done_mem_req", 32'(bus.mem_req), 32'd0);
        chk("done_busy", 32'(bus.fill_busy), 32'd1);
      end
    end else if (bus.fill_err) begin
      chk("err_without_done", 32'(bus.fill_err), 32'd0);
    end
    if (bus.mem_req && !prev_req) begin
      if (exp_addr.size() == 0) begin
        chk("unexpected_req", 32'(bus.mem_req), 32'd0);
      end else begin
        ma = exp_addr.pop_front();
        chk("req_cycle", 32'(cyc), 32'(ma.cyc));
        chk("req_addr", bus.mem_addr, ma.addr);
        chk("req_busy", 32'(bus.fill_busy), 32'd1);
      end
    end
    prev_req = bus.mem_req;
  end

  initial begin
    clear_inputs();
    bus.miss_addr = '0;
    rst_n = 1'b0;
    step();
    step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();
    check_quiet("post_reset_idle");

    // Line-aligned fill, late ack, back-to-back indexed data.
    run_fill(32'h0000_1234, 2, 0, 1'b1, 1'b0, -1);
    idle_noise(2);
    // Beats every other cycle.
    run_fill(32'h0000_5A40, 1, 1, 1'b1, 1'b0, -1);
    idle_noise(2);
    // No ack ever: stall abort.
    run_fill(32'h0000_2000, 1000, 0, 1'b1, 1'b0, -1);
    idle_noise(2);
    // Miss in the last words of the line.
    run_fill(32'h0000_1278, 0, 0, 1'b1, 1'b0, -1);
    // Chatter on miss_req during the fill and mem_valid while idle.
    idle_noise(8);
    run_fill(32'h0000_0ABC, 1, 2, 1'b0, 1'b1, -1);
    idle_noise(4);
    // Reset after 10 beats, then a normal fill.
    run_fill(32'h0000_3344, 1, 0, 1'b1, 1'b0, 10);
    run_fill(32'h0000_3344, 0, 2, 1'b0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      idle_noise($urandom_range(0, 3));
      run_fill($urandom, ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4),
               3, 1'b0, 1'b1, -1);
    end

    idle_noise(4);
    chk("left_writes", 32'(exp_wr.size()), 32'd0);
    chk("left_dones", 32'(exp_done.size()), 32'd0);
    chk("left_reqs", 32'(exp_addr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
